// File: rtl/lib_axis_demux_pkg.sv
// Helpers shared by the demux: destination-field sizing.
// Combinational constants only; no latency or backpressure involvement.
package lib_axis_demux_pkg;

    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ofs_pcie_ss_cfg_pkg.sv
// Stream widths used by the PCIe subsystem AXI-S wrappers.
// Constants only; no latency or backpressure involvement.
package ofs_pcie_ss_cfg_pkg;

    localparam int TDATA_WIDTH = 64;
    localparam int TUSER_WIDTH = 10;

endpackage

// File: rtl/pcie_ss_axis_if.sv
// AXI-S bundle with tkeep and tuser_vendor; clk/rst_n travel with the bundle.
// Wires only; tvalid/tready handshake owned by the endpoints.
interface pcie_ss_axis_if #(
    parameter int DATA_W = ofs_pcie_ss_cfg_pkg::TDATA_WIDTH,
    parameter int USER_W = ofs_pcie_ss_cfg_pkg::TUSER_WIDTH
) (
    input logic clk,
    input logic rst_n
);
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [DATA_W-1:0]     tdata;
    logic [DATA_W/8-1:0]   tkeep;
    logic [USER_W-1:0]     tuser_vendor;

    modport sink   (input clk, rst_n, tvalid, tlast, tdata, tkeep, tuser_vendor, output tready);
    modport source (input clk, rst_n, tready, output tvalid, tlast, tdata, tkeep, tuser_vendor);
endinterface

// File: rtl/lib_axis_route_lock.sv
// Tracks packet start, latches the destination for the whole packet, counts drops.
// Destination is combinational from the SOP beat; drop count/pulse update 1 cycle after tlast.
module lib_axis_route_lock #(
    parameter int NUM_CH = 2,
    parameter int DW     = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          beat_vld_i,
    input  logic          beat_rdy_i,
    input  logic          beat_last_i,
    input  logic [DW-1:0] sel_i,
    output logic [DW-1:0] dest_o,
    output logic          dest_ok_o,
    output logic [15:0]   drop_cnt_o,
    output logic          drop_pulse_o
);
    localparam logic [DW:0] NCH = (DW+1)'(NUM_CH);

    logic          sop_q;
    logic [DW-1:0] dest_q;
    logic [DW-1:0] dest_d;
    logic [15:0]   drop_cnt_q;
    logic          drop_pulse_q;

    assign dest_d    = sop_q ? sel_i : dest_q;
    assign dest_o    = (NUM_CH == 1) ? '0 : dest_d;
    assign dest_ok_o = (NUM_CH == 1) || ({1'b0, dest_o} < NCH);

    always_ff @(posedge clk) begin
        if (rst) begin
            sop_q        <= 1'b1;
            dest_q       <= '0;
            drop_cnt_q   <= '0;
            drop_pulse_q <= 1'b0;
        end else begin
            drop_pulse_q <= 1'b0;
            if (beat_vld_i && beat_rdy_i) begin
                sop_q <= beat_last_i;
                if (sop_q) begin
                    dest_q <= dest_o;
                end
                if (!dest_ok_o && beat_last_i) begin
                    drop_pulse_q <= 1'b1;
                    if (drop_cnt_q != 16'hFFFF) begin
                        drop_cnt_q <= drop_cnt_q + 16'd1;
                    end
                end
            end
        end
    end

    assign drop_cnt_o   = drop_cnt_q;
    assign drop_pulse_o = drop_pulse_q;

endmodule

// File: rtl/ofs_fim_axis_pipeline.sv
// Two-entry skid stage that fully registers an AXI-S stream, forward and backward.
// Latency 1 cycle; upstream tready is a flop, dropping one cycle after output stalls.
module ofs_fim_axis_pipeline #(
    parameter int TDATA_WIDTH = ofs_pcie_ss_cfg_pkg::TDATA_WIDTH,
    parameter int TUSER_WIDTH = ofs_pcie_ss_cfg_pkg::TUSER_WIDTH
) (
    pcie_ss_axis_if.sink   axis_s,
    pcie_ss_axis_if.source axis_m
);
    localparam int KW = TDATA_WIDTH / 8;
    localparam int BW = TDATA_WIDTH + KW + 1 + TUSER_WIDTH;

    logic [BW-1:0] in_beat;
    logic [BW-1:0] m_dat_q;
    logic [BW-1:0] s_dat_q;
    logic          m_vld_q;
    logic          s_vld_q;
    logic          m_adv;

    assign in_beat       = {axis_s.tdata, axis_s.tkeep, axis_s.tlast, axis_s.tuser_vendor};
    assign axis_s.tready = ~s_vld_q;
    assign m_adv         = ~m_vld_q | axis_m.tready;

    always_ff @(posedge axis_m.clk) begin
        if (!axis_m.rst_n) begin
            m_vld_q <= 1'b0;
            s_vld_q <= 1'b0;
        end else if (m_adv) begin
            m_vld_q <= s_vld_q | axis_s.tvalid;
            s_vld_q <= 1'b0;
        end else if (axis_s.tvalid && !s_vld_q) begin
            s_vld_q <= 1'b1;
        end
    end

    // Skid entry only fills when the head is stalled and the input is still open.
    always_ff @(posedge axis_m.clk) begin
        if (m_adv) begin
            m_dat_q <= s_vld_q ? s_dat_q : in_beat;
        end
        if (!m_adv && axis_s.tvalid && !s_vld_q) begin
            s_dat_q <= in_beat;
        end
    end

    assign axis_m.tvalid = m_vld_q;
    assign {axis_m.tdata, axis_m.tkeep, axis_m.tlast, axis_m.tuser_vendor} = m_dat_q;

endmodule

// File: rtl/lib_axis_demux.sv
// Routes packets from one AXI-S input to NUM_CH outputs by a field in the SOP beat.
// Latency 2 cycles; stalls only on the selected channel (head-of-line), drops never stall.
module lib_axis_demux
    import lib_axis_demux_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int TDATA_WIDTH = ofs_pcie_ss_cfg_pkg::TDATA_WIDTH,
    parameter int TUSER_WIDTH = ofs_pcie_ss_cfg_pkg::TUSER_WIDTH,
    parameter int SEL_LSB     = 0
) (
    input  logic           clk,
    input  logic           rst,
    pcie_ss_axis_if.sink   sink,
    pcie_ss_axis_if.source source [NUM_CH],
    output logic [15:0]    drop_cnt,
    output logic           drop_pulse
);
    localparam int DW    = sel_width(NUM_CH);
    localparam int NSLOT = 1 << DW;

    logic             rst_n;
    logic [DW-1:0]    dest;
    logic             dest_ok;
    logic [NSLOT-1:0] out_rdy;

    assign rst_n = ~rst;

    pcie_ss_axis_if #(.DATA_W(TDATA_WIDTH), .USER_W(TUSER_WIDTH)) skid_if (.clk(clk), .rst_n(rst_n));

    ofs_fim_axis_pipeline #(
        .TDATA_WIDTH (TDATA_WIDTH),
        .TUSER_WIDTH (TUSER_WIDTH)
    ) u_skid (
        .axis_s (sink),
        .axis_m (skid_if)
    );

    lib_axis_route_lock #(
        .NUM_CH (NUM_CH),
        .DW     (DW)
    ) u_lock (
        .clk          (clk),
        .rst          (rst),
        .beat_vld_i   (skid_if.tvalid),
        .beat_rdy_i   (skid_if.tready),
        .beat_last_i  (skid_if.tlast),
        .sel_i        (skid_if.tdata[SEL_LSB +: DW]),
        .dest_o       (dest),
        .dest_ok_o    (dest_ok),
        .drop_cnt_o   (drop_cnt),
        .drop_pulse_o (drop_pulse)
    );

    // Invalid destinations are swallowed so a bad packet can never wedge the input.
    assign skid_if.tready = dest_ok ? out_rdy[dest] : 1'b1;

    for (genvar c = 0; c < NSLOT; c++) begin : g_ch
        if (c < NUM_CH) begin : g_out
            logic                     vld_q;
            logic                     ld;
            logic [TDATA_WIDTH-1:0]   tdata_q;
            logic [TDATA_WIDTH/8-1:0] tkeep_q;
            logic                     tlast_q;
            logic [TUSER_WIDTH-1:0]   tuser_q;

            assign out_rdy[c] = ~vld_q | source[c].tready;
            assign ld = skid_if.tvalid & dest_ok & (dest == DW'(c)) & out_rdy[c];

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q <= 1'b0;
                end else if (out_rdy[c]) begin
                    vld_q <= ld;
                end
            end

            always_ff @(posedge clk) begin
                if (ld) begin
                    tdata_q <= skid_if.tdata;
                    tkeep_q <= skid_if.tkeep;
                    tlast_q <= skid_if.tlast;
                    tuser_q <= skid_if.tuser_vendor;
                end
            end

            assign source[c].tvalid       = vld_q;
            assign source[c].tdata        = tdata_q;
            assign source[c].tkeep        = tkeep_q;
            assign source[c].tlast        = tlast_q;
            assign source[c].tuser_vendor = tuser_q;
        end else begin : g_pad
            assign out_rdy[c] = 1'b1;
        end
    end

endmodule

// File: tb/tb_lib_axis_demux.sv
// Scoreboard bench: a 4-channel and a 3-channel demux driven by directed packets.
`timescale 1ns/1ps
module tb_lib_axis_demux;
    import ofs_pcie_ss_cfg_pkg::*;

    localparam int TDW = TDATA_WIDTH;
    localparam int TUW = TUSER_WIDTH;

    typedef struct {
        logic [63:0] dat;
        logic        last;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst_n;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    exp_t        exp_q [8][$];
    int          pulses [2];
    int          pulse_cyc [2];
    int          stalls [2];
    int          last_hs_cyc;
    int          stall_c0;
    int          stall_c1;
    bit          stall_arm = 1'b0;

    logic [1:0]  drv_vld;
    logic [63:0] drv_dat [2];
    logic [1:0]  drv_last;
    logic [1:0]  sink_rdy;
    logic [3:0]  rdy4;
    logic [2:0]  rdy3;
    logic [3:0]  v4;
    logic [2:0]  v3;
    logic [15:0] dc4, dc3;
    logic        dp4, dp3;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign rst_n = ~rst;

    pcie_ss_axis_if #(.DATA_W(TDW), .USER_W(TUW)) s4 (.clk(clk), .rst_n(rst_n));
    pcie_ss_axis_if #(.DATA_W(TDW), .USER_W(TUW)) s3 (.clk(clk), .rst_n(rst_n));
    pcie_ss_axis_if #(.DATA_W(TDW), .USER_W(TUW)) o4 [4] (.clk(clk), .rst_n(rst_n));
    pcie_ss_axis_if #(.DATA_W(TDW), .USER_W(TUW)) o3 [3] (.clk(clk), .rst_n(rst_n));

    assign s4.tvalid       = drv_vld[0];
    assign s4.tdata        = drv_dat[0];
    assign s4.tkeep        = drv_dat[0][15:8];
    assign s4.tuser_vendor = drv_dat[0][25:16];
    assign s4.tlast        = drv_last[0];
    assign sink_rdy[0]     = s4.tready;
    assign s3.tvalid       = drv_vld[1];
    assign s3.tdata        = drv_dat[1];
    assign s3.tkeep        = drv_dat[1][15:8];
    assign s3.tuser_vendor = drv_dat[1][25:16];
    assign s3.tlast        = drv_last[1];
    assign sink_rdy[1]     = s3.tready;

    lib_axis_demux #(.NUM_CH(4), .SEL_LSB(0)) dut4 (
        .clk(clk), .rst(rst), .sink(s4), .source(o4), .drop_cnt(dc4), .drop_pulse(dp4)
    );
    lib_axis_demux #(.NUM_CH(3), .SEL_LSB(0)) dut3 (
        .clk(clk), .rst(rst), .sink(s3), .source(o3), .drop_cnt(dc3), .drop_pulse(dp3)
    );

    function automatic void chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void mon_beat(input int d, input int c, input logic [63:0] dat,
                                     input logic [7:0] keep, input logic [9:0] user, input logic last);
        exp_t e;
        int   qi;
        qi = d * 4 + c;
        n_tests++;
        if (exp_q[qi].size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_beat dut%0d ch%0d: got data 0x%0h, expected no beat", d, c, dat);
            return;
        end
        e = exp_q[qi].pop_front();
        if (dat !== e.dat || last !== e.last || keep !== e.dat[15:8] || user !== e.dat[25:16] ||
            (e.cyc >= 0 && cyc != e.cyc)) begin
            n_fail++;
            $display("FAIL beat dut%0d ch%0d: got data 0x%0h last %0b cyc %0d, expected data 0x%0h last %0b cyc %0d",
                     d, c, dat, last, cyc, e.dat, e.last, e.cyc);
        end
    endfunction

    for (genvar c = 0; c < 4; c++) begin : g_m4
        assign o4[c].tready = rdy4[c];
        assign v4[c] = o4[c].tvalid;
        always @(negedge clk)
            if (!rst && o4[c].tvalid && o4[c].tready)
                mon_beat(0, c, o4[c].tdata, o4[c].tkeep, o4[c].tuser_vendor, o4[c].tlast);
    end
    for (genvar c = 0; c < 3; c++) begin : g_m3
        assign o3[c].tready = rdy3[c];
        assign v3[c] = o3[c].tvalid;
        always @(negedge clk)
            if (!rst && o3[c].tvalid && o3[c].tready)
                mon_beat(1, c, o3[c].tdata, o3[c].tkeep, o3[c].tuser_vendor, o3[c].tlast);
    end

    always @(negedge clk) begin
        if (dp4) begin pulses[0]++; pulse_cyc[0] = cyc; end
        if (dp3) begin pulses[1]++; pulse_cyc[1] = cyc; end
        if (stall_arm && stall_c1 < 0 && !sink_rdy[0]) stall_c1 = cyc;
    end

    task automatic send_beat(input int d, input logic [63:0] dat, input bit last,
                             input int ch, input bit push, input bit lat);
        int   waited;
        exp_t e;
        waited = 0;
        drv_vld[d]  = 1'b1;
        drv_dat[d]  = dat;
        drv_last[d] = last;
        forever begin
            @(negedge clk);
            if (sink_rdy[d]) break;
            waited++;
            if (waited > 300) begin
                n_tests++;
                n_fail++;
                $display("FAIL sink_timeout dut%0d: got no tready in %0d cycles, expected tready", d, waited);
                drv_vld[d] = 1'b0;
                return;
            end
        end
        stalls[d] += waited;
        last_hs_cyc = cyc;
        if (push && ch >= 0) begin
            e.dat  = dat;
            e.last = last;
            e.cyc  = lat ? cyc + 2 : -1;
            exp_q[d * 4 + ch].push_back(e);
        end
        @(posedge clk);
        #1;
        drv_vld[d] = 1'b0;
    endtask

    task automatic send_pkt(input int d, input int nb, input int dest, input logic [47:0] tag, input bit lat);
        int          ch;
        logic [63:0] dat;
        ch = (dest < ((d == 0) ? 4 : 3)) ? dest : -1;
        for (int k = 0; k < nb; k++) begin
            dat = {tag, 8'(k), (k == 0) ? 8'(dest) : 8'(dest + 1)};
            send_beat(d, dat, k == nb - 1, ch, 1'b1, lat);
        end
    endtask

    task automatic blast(input int n);
        int got;
        int guard;
        got = 0;
        guard = 0;
        drv_vld[1]  = 1'b1;
        drv_dat[1]  = 64'h3;
        drv_last[1] = 1'b1;
        while (got < n && guard < n + 100) begin
            @(negedge clk);
            if (sink_rdy[1]) got++;
            guard++;
            @(posedge clk);
            #1;
        end
        drv_vld[1] = 1'b0;
        chk("drop_stream_accepted_without_stall", got, n);
    endtask

    task automatic wait_drain();
        int left;
        for (int t = 0; t < 200; t++) begin
            left = 0;
            for (int i = 0; i < 8; i++) left += exp_q[i].size();
            if (left == 0) break;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        left = 0;
        for (int i = 0; i < 8; i++) left += exp_q[i].size();
        chk("beats_outstanding", left, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (95000) @(posedge clk);
        n_fail++;
        $display("FAIL watchdog: got %0d cycles, expected completion earlier", cyc);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        drv_vld  = '0;
        drv_last = '0;
        drv_dat[0] = '0;
        drv_dat[1] = '0;
        rdy4 = '1;
        rdy3 = '1;
        pulses[0] = 0; pulses[1] = 0;
        pulse_cyc[0] = -1; pulse_cyc[1] = -1;
        stalls[0] = 0; stalls[1] = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_tvalid4", v4, 0);
        chk("reset_tvalid3", v3, 0);
        chk("reset_drop_cnt4", dc4, 0);
        chk("reset_drop_cnt3", dc3, 0);
        chk("reset_drop_pulse4", dp4, 0);
        chk("reset_drop_pulse3", dp3, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 3-beat packet to channel 2 with exact latency
        send_pkt(0, 3, 2, 48'hA1A1_0000_0001, 1'b1);
        wait_drain();

        // back-to-back single-beat packets
        send_pkt(0, 1, 0, 48'hB0B0_0000_0010, 1'b1);
        send_pkt(0, 1, 1, 48'hB0B0_0000_0011, 1'b1);
        send_pkt(0, 1, 0, 48'hB0B0_0000_0012, 1'b1);
        send_pkt(0, 1, 3, 48'hB0B0_0000_0013, 1'b1);
        wait_drain();
        chk("no_drops_4ch_cnt", dc4, 0);
        chk("no_drops_4ch_pulses", pulses[0], 0);

        // backpressure on channel 1 for 10 cycles mid-packet
        stall_c1 = -1;
        fork
            send_pkt(0, 8, 1, 48'hC3C3_0000_0020, 1'b0);
            begin
                repeat (3) @(posedge clk);
                #1;
                rdy4[1]   = 1'b0;
                stall_c0  = cyc;
                stall_arm = 1'b1;
                repeat (10) @(posedge clk);
                #1;
                rdy4[1]   = 1'b1;
                stall_arm = 1'b0;
            end
        join
        chk("sink_stall_within_2", (stall_c1 >= 0 && stall_c1 - stall_c0 <= 2), 1);
        wait_drain();

        // reset mid-packet, then next beat is a fresh SOP
        rdy4[0] = 1'b0;
        send_beat(0, {48'hD5D5_0000_0030, 8'd0, 8'd0}, 1'b0, 0, 1'b0, 1'b0);
        send_beat(0, {48'hD5D5_0000_0030, 8'd1, 8'd1}, 1'b0, 0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midpkt_reset_tvalid4", v4, 0);
        @(posedge clk);
        #1 rdy4[0] = 1'b1;
        send_pkt(0, 1, 2, 48'hE6E6_0000_0040, 1'b1);
        wait_drain();

        // invalid destination on the 3-channel instance
        chk("drop_cnt_before", dc3, 0);
        stalls[1] = 0;
        send_pkt(1, 3, 3, 48'hF7F7_0000_0050, 1'b0);
        repeat (4) @(negedge clk);
        chk("drop_cnt_after_one", dc3, 1);
        chk("drop_pulse_cycles", pulses[1], 1);
        chk("drop_pulse_timing", pulse_cyc[1], last_hs_cyc + 2);
        chk("drop_sink_no_stall", stalls[1], 0);
        @(posedge clk);
        #1;
        send_pkt(1, 2, 1, 48'h1818_0000_0060, 1'b1);
        wait_drain();

        // drive the drop counter to saturation
        blast(65533);
        repeat (4) @(negedge clk);
        chk("drop_cnt_fffe", dc3, 16'hFFFE);
        p0 = pulses[1];
        @(posedge clk);
        #1;
        blast(3);
        repeat (4) @(negedge clk);
        chk("drop_cnt_saturated", dc3, 16'hFFFF);
        chk("drop_pulses_at_saturation", pulses[1] - p0, 3);
        @(posedge clk);
        #1;
        blast(1);
        repeat (4) @(negedge clk);
        chk("drop_cnt_stays_saturated", dc3, 16'hFFFF);
        chk("drop_pulses_total", pulses[1], 65538);
        chk("no_drops_4ch_final", dc4, 0);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
